// File: rtl/req_busy_ack_responder_pkg.sv
// Shared types and limits for the req/busy/ack responder.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACKED = 2'd2
  } resp_state_e;

  typedef logic [2:1] req_id_t;

  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/req_busy_ack_responder_svc_timer.sv
// Service-latency down-counter: load a start value, decrement to zero, flag zero.
module svc_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/req_busy_ack_responder.sv
// Target-side four-phase responder: accept req, raise busy, ack after
// LATENCY edges echoing the captured id, and close when req drops.
// Valid/ready contract: req is a level held by the requester until it sees
// ack; busy means the request was accepted; ack means service is done and
// stays high until req is sampled low. Dropping req before ack is an abort
// that pulses err for one cycle.
module req_busy_ack_responder
  import req_ack_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  req_id_t     id,
  output logic        busy,
  output logic        ack,
  output req_id_t     ack_id,
  output logic        err,
  output logic [7:0]  done_cnt,
  output resp_state_e dbg_state
);

  if ((LATENCY < 1) || (LATENCY > MAX_LATENCY) || ((LATENCY - 1) >= (1 << CNT_W))) begin : g_bad_params
    $error("req_busy_ack_responder: LATENCY out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  resp_state_e r_state;
  resp_state_e w_next_state;

  logic       r_busy;
  logic       r_ack;
  req_id_t    r_ack_id;
  logic       r_err;
  logic [7:0] r_done_cnt;
  req_id_t    r_cap_id;

  logic       w_load;
  logic       w_dec;
  logic       w_zero;
  logic       w_cap_en;
  logic       w_busy_d;
  logic       w_ack_d;
  req_id_t    w_ack_id_d;
  logic       w_err_d;
  logic       w_done_inc;

  svc_timer #(.CNT_W(CNT_W)) u_svc_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and next output values; abort wins over service completion.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_cap_en     = 1'b0;
    w_busy_d     = r_busy;
    w_ack_d      = r_ack;
    w_ack_id_d   = r_ack_id;
    w_err_d      = 1'b0;
    w_done_inc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_next_state = SERVE;
          w_load       = 1'b1;
          w_cap_en     = 1'b1;
          w_busy_d     = 1'b1;
        end
      end
      SERVE: begin
        if (!req) begin
          w_next_state = IDLE;
          w_busy_d     = 1'b0;
          w_err_d      = 1'b1;
        end else if (w_zero) begin
          w_next_state = ACKED;
          w_ack_d      = 1'b1;
          w_ack_id_d   = r_cap_id;
        end else begin
          w_dec = 1'b1;
        end
      end
      ACKED: begin
        if (!req) begin
          w_next_state = IDLE;
          w_busy_d     = 1'b0;
          w_ack_d      = 1'b0;
          w_ack_id_d   = '0;
          w_done_inc   = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_busy_d     = 1'b0;
        w_ack_d      = 1'b0;
        w_ack_id_d   = '0;
      end
    endcase
  end

  // Output registers, id capture and completed-handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_ack_id   <= '0;
      r_err      <= 1'b0;
      r_done_cnt <= 8'd0;
      r_cap_id   <= '0;
    end else begin
      r_busy   <= w_busy_d;
      r_ack    <= w_ack_d;
      r_ack_id <= w_ack_id_d;
      r_err    <= w_err_d;
      if (w_cap_en) begin
        r_cap_id <= id;
      end
      if (w_done_inc) begin
        r_done_cnt <= r_done_cnt + 8'd1;
      end
    end
  end

  assign busy      = r_busy;
  assign ack       = r_ack;
  assign ack_id    = r_ack_id;
  assign err       = r_err;
  assign done_cnt  = r_done_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_req_busy_ack_responder.sv
// Bench for req_busy_ack_responder: two builds (LATENCY=3 and LATENCY=1)
// driven by the same req/id, each checked against a handshake-level model.
module tb_req_busy_ack_responder;
  import req_ack_pkg::*;

  logic clk;
  logic reset;
  logic req;
  logic [1:0] id;

  logic        busy_s   [2];
  logic        ack_s    [2];
  logic [1:0]  ack_id_s [2];
  logic        err_s    [2];
  logic [7:0]  done_s   [2];
  resp_state_e st_s     [2];

  int checks = 0;
  int errors = 0;

  // Reference model: per build, whether a handshake is open, how many
  // edges since it was accepted, the accepted id and the completion count.
  int         lat      [2] = '{3, 1};
  bit         m_active [2];
  int         m_age    [2];
  logic [1:0] m_cap    [2];
  logic [7:0] m_done   [2];
  bit         m_err    [2];

  req_busy_ack_responder #(.LATENCY(3), .CNT_W(4)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .id        (id),
    .busy      (busy_s[0]),
    .ack       (ack_s[0]),
    .ack_id    (ack_id_s[0]),
    .err       (err_s[0]),
    .done_cnt  (done_s[0]),
    .dbg_state (st_s[0])
  );

  req_busy_ack_responder #(.LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .id        (id),
    .busy      (busy_s[1]),
    .ack       (ack_s[1]),
    .ack_id    (ack_id_s[1]),
    .err       (err_s[1]),
    .done_cnt  (done_s[1]),
    .dbg_state (st_s[1])
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_age[i]    = 0;
      m_cap[i]    = 2'b00;
      m_done[i]   = 8'd0;
      m_err[i]    = 1'b0;
    end
  endtask

  // One clock edge of the four-phase rules, seen from the requester's side.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 1'b0;
      if (!m_active[i]) begin
        if (req === 1'b1) begin
          m_active[i] = 1'b1;
          m_age[i]    = 0;
          m_cap[i]    = id;
        end
      end else if (req !== 1'b1) begin
        if (m_age[i] >= lat[i]) m_done[i] = m_done[i] + 8'd1;
        else                    m_err[i]  = 1'b1;
        m_active[i] = 1'b0;
      end else if (m_age[i] < 100) begin
        m_age[i] = m_age[i] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[lat=%0d]: observed %0h expected %0h", tag, lat[inst], obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_ack;
    for (int i = 0; i < 2; i++) begin
      exp_ack = m_active[i] && (m_age[i] >= lat[i]);
      check("busy",   i, {7'd0, busy_s[i]}, {7'd0, m_active[i]});
      check("ack",    i, {7'd0, ack_s[i]},  {7'd0, exp_ack});
      check("ack_id", i, {6'd0, ack_id_s[i]}, exp_ack ? {6'd0, m_cap[i]} : 8'd0);
      check("err",    i, {7'd0, err_s[i]},  {7'd0, m_err[i]});
      check("done",   i, done_s[i], m_done[i]);
      check("state_open", i, {7'd0, (st_s[i] != IDLE)}, {7'd0, m_active[i]});
    end
  endtask

  // Inputs are stable around the edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    id    = 2'b00;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Nominal handshake, id 2'b10, req dropped two edges after ack.
    req = 1'b1;
    id  = 2'b10;
    repeat (6) step();
    check("nom_ack_id", 0, {6'd0, ack_id_s[0]}, 8'h02);
    req = 1'b0;
    repeat (3) step();
    check("nom_done", 0, done_s[0], 8'd1);

    // Abort: req high two edges, then low before the LATENCY=3 ack.
    req = 1'b1;
    id  = 2'b01;
    repeat (2) step();
    req = 1'b0;
    step();
    check("abort_err", 0, {7'd0, err_s[0]}, 8'd1);
    step();
    check("abort_err_clear", 0, {7'd0, err_s[0]}, 8'd0);
    check("abort_done", 0, done_s[0], 8'd1);

    // Back-to-back: req back high right after close, with a new id.
    req = 1'b1;
    id  = 2'b11;
    repeat (5) step();
    req = 1'b0;
    step();
    req = 1'b1;
    id  = 2'b01;
    repeat (5) step();
    check("b2b_ack_id", 0, {6'd0, ack_id_s[0]}, 8'h01);
    req = 1'b0;
    repeat (2) step();

    // id changes during service are ignored.
    req = 1'b1;
    id  = 2'b10;
    step();
    id = 2'b11;
    step();
    check("lat1_ack_id", 1, {6'd0, ack_id_s[1]}, 8'h02);
    repeat (3) step();
    req = 1'b0;
    repeat (2) step();

    // Random req/id traffic.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) req = ~req;
      id = 2'($urandom_range(0, 3));
      step();
    end
    req = 1'b0;
    repeat (2) step();

    // Reset asserted between edges while the LATENCY=3 build is acked.
    req = 1'b1;
    id  = 2'b11;
    repeat (5) step();
    check("pre_reset_ack", 0, {7'd0, ack_s[0]}, 8'd1);
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    req = 1'b0;
    #1;
    reset = 1'b0;
    repeat (2) step();

    // Wrap of the completion counter over 257 handshakes.
    for (int k = 0; k < 257; k++) begin
      req = 1'b1;
      id  = 2'($urandom_range(0, 3));
      repeat (4) step();
      req = 1'b0;
      step();
      if (k == 255) begin
        check("wrap_zero", 0, done_s[0], 8'd0);
        check("wrap_zero", 1, done_s[1], 8'd0);
      end
      if (k == 256) begin
        check("wrap_one", 0, done_s[0], 8'd1);
        check("wrap_one", 1, done_s[1], 8'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
